// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
//   Shared constants and types for the Pong joystick/paddle path.
//   - Screen and paddle geometry, joystick rest code and dead-zone.
//   - Paddle direction encodings and the paddle controller state enum.
//   - speed_for(): maps a joystick deflection magnitude to lines per frame.
// -----------------------------------------------------------------------------
package pong_pkg;

    localparam int SCREEN_H     = 480;
    localparam int PADDLE_H     = 80;
    localparam int CENTER       = 512;
    localparam int DEADZONE     = 64;
    localparam int MAX_SPEED    = 8;
    localparam int STALE_FRAMES = 8;

    localparam int Y_MAX   = SCREEN_H - PADDLE_H;   // lowest legal top edge
    localparam int Y_RESET = Y_MAX / 2;             // centred paddle

    localparam logic [1:0] DIR_STILL = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        STALE = 2'd2
    } state_t;

    // One extra line per frame for every 32 codes beyond the dead-zone,
    // capped at MAX_SPEED.
    function automatic logic [3:0] speed_for(input logic [10:0] mag);
        logic [10:0] steps;
        if (mag <= 11'(DEADZONE)) begin
            return 4'd0;
        end
        steps = ((mag - 11'(DEADZONE)) >> 5) + 11'd1;
        if (steps > 11'(MAX_SPEED)) begin
            return 4'(MAX_SPEED);
        end
        return steps[3:0];
    endfunction

endpackage

// File: rtl/joystick_paddle_ctrl_if.sv
// -----------------------------------------------------------------------------
// joystick_paddle_ctrl_if
//   Bundles the joystick sample stream, the frame strobe and the paddle outputs.
//   master : sample source / frame timing side (drives samples and frame_tick)
//   slave  : paddle controller (consumes samples, drives paddle_y/dir/stale)
// -----------------------------------------------------------------------------
interface joystick_paddle_ctrl_if;

    logic       sample_valid;  // 1-cycle strobe, sample_y is new
    logic [9:0] sample_y;      // raw joystick code, high = stick up
    logic       frame_tick;    // 1-cycle strobe per video frame
    logic [9:0] paddle_y;      // paddle top edge in screen lines
    logic [1:0] paddle_dir;    // 00 still, 01 down, 10 up
    logic       stale;         // joystick link considered dead

    modport master (
        output sample_valid, sample_y, frame_tick,
        input  paddle_y, paddle_dir, stale
    );

    modport slave (
        input  sample_valid, sample_y, frame_tick,
        output paddle_y, paddle_dir, stale
    );

endinterface

// File: rtl/joy_avg4.sv
// -----------------------------------------------------------------------------
// joy_avg4
//   4-tap moving average of joystick samples with a running 12-bit sum.
//   Unfilled taps hold zero so the running sum is exact from the first sample.
//   Ports:
//     clk50M, rst_n  clock / async active-low reset
//     sample_valid   accept sample_y this cycle
//     sample_y       10-bit raw sample
//     restart        with sample_valid: discard history, sample_y becomes tap 0
//     avg            sum/4, reflects samples accepted up to the previous edge
//     fill_count     number of valid taps, saturates at 4
// -----------------------------------------------------------------------------
module joy_avg4 (
    input  logic       clk50M,
    input  logic       rst_n,
    input  logic       sample_valid,
    input  logic [9:0] sample_y,
    input  logic       restart,
    output logic [9:0] avg,
    output logic [2:0] fill_count
);

    logic [9:0]  taps [4];
    logic [11:0] sum_q;
    logic [2:0]  count_q;

    // NOTE: the tap storage is reset on purpose; a partially filled buffer must
    // never leak into the running sum after a reset or a refill.
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) taps[i] <= '0;
            sum_q   <= '0;
            count_q <= '0;
        end else if (sample_valid) begin
            if (restart) begin
                taps[0] <= sample_y;
                for (int i = 1; i < 4; i++) taps[i] <= '0;
                sum_q   <= 12'(sample_y);
                count_q <= 3'd1;
            end else begin
                taps[0] <= sample_y;
                for (int i = 1; i < 4; i++) taps[i] <= taps[i-1];
                sum_q   <= sum_q + 12'(sample_y) - 12'(taps[3]);
                count_q <= (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;
            end
        end
    end

    assign avg        = 10'(sum_q >> 2);
    assign fill_count = count_q;

endmodule

// File: rtl/joystick_paddle_ctrl.sv
// -----------------------------------------------------------------------------
// joystick_paddle_ctrl
//   Turns filtered joystick samples into a clamped paddle position, updated once
//   per frame tick with a deflection-proportional speed. A link that delivers no
//   sample for STALE_FRAMES ticks freezes the paddle until samples resume and
//   the filter has refilled.
//   Ports:
//     clk50M  50 MHz system clock
//     rst_n   asynchronous active-low reset
//     bus     joystick_paddle_ctrl_if.slave (samples in, paddle state out)
// -----------------------------------------------------------------------------
module joystick_paddle_ctrl
    import pong_pkg::*;
(
    input  logic                          clk50M,
    input  logic                          rst_n,
    joystick_paddle_ctrl_if.slave         bus
);

    state_t      state_q, state_d;
    logic [3:0]  idle_q, idle_d;        // frame ticks since the last sample
    logic [9:0]  paddle_y_q, paddle_y_d;
    logic [1:0]  dir_q, dir_d;
    logic        restart;
    logic [9:0]  avg;
    logic [2:0]  fill_count;

    logic signed [10:0] offset, pos, step, target;
    logic        [10:0] mag;
    logic        [3:0]  speed;
    logic        [9:0]  move_y;
    logic        [1:0]  move_dir;

    joy_avg4 u_avg (
        .clk50M       (clk50M),
        .rst_n        (rst_n),
        .sample_valid (bus.sample_valid),
        .sample_y     (bus.sample_y),
        .restart      (restart),
        .avg          (avg),
        .fill_count   (fill_count)
    );

    // Candidate move from the current (pre-update) average.
    always_comb begin
        offset = $signed({1'b0, avg}) - $signed(11'(CENTER));
        mag    = offset[10] ? 11'(-offset) : 11'(offset);
        speed  = speed_for(mag);
        step   = $signed({7'b0, speed});
        pos    = $signed({1'b0, paddle_y_q});
        // Stick pushed up (positive offset) moves the paddle towards line 0.
        target = (offset > 11'sd0) ? pos - step : pos + step;
        if (target < 11'sd0)                         move_y = '0;
        else if (target > $signed(11'(Y_MAX)))       move_y = 10'(Y_MAX);
        else                                         move_y = target[9:0];
        if (move_y == paddle_y_q)                    move_dir = DIR_STILL;
        else if (offset > 11'sd0)                    move_dir = DIR_UP;
        else                                         move_dir = DIR_DOWN;
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        idle_d     = idle_q;
        paddle_y_d = paddle_y_q;
        dir_d      = dir_q;
        restart    = 1'b0;
        unique case (state_q)
            FILL: begin
                idle_d = '0;
                if (bus.frame_tick) dir_d = DIR_STILL;
                if (bus.sample_valid && fill_count >= 3'd3) state_d = RUN;
            end
            RUN: begin
                if (bus.sample_valid)    idle_d = '0;
                else if (bus.frame_tick) idle_d = idle_q + 4'd1;
                if (bus.frame_tick) begin
                    // The tick that completes the silent interval freezes instead of moving.
                    if (!bus.sample_valid && idle_q == 4'(STALE_FRAMES - 1)) begin
                        state_d = STALE;
                        dir_d   = DIR_STILL;
                    end else begin
                        paddle_y_d = move_y;
                        dir_d      = move_dir;
                    end
                end
            end
            STALE: begin
                idle_d = '0;
                if (bus.frame_tick) dir_d = DIR_STILL;
                if (bus.sample_valid) begin
                    state_d = FILL;
                    restart = 1'b1;
                end
            end
            default: begin
                state_d = FILL;
                idle_d  = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block ordering.
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            idle_q     <= '0;
            paddle_y_q <= 10'(Y_RESET);
            dir_q      <= DIR_STILL;
        end else begin
            state_q    <= state_d;
            idle_q     <= idle_d;
            paddle_y_q <= paddle_y_d;
            dir_q      <= dir_d;
        end
    end

    assign bus.paddle_y   = paddle_y_q;
    assign bus.paddle_dir = dir_q;
    assign bus.stale      = (state_q == STALE);

endmodule
